gpio_link_rx: RTL and testbench
===============================

# gpio_link_rx

Receive side of the two-board GPIO button link. The remote board drives its mouse-button state onto two GPIO lines. This block brings those lines into the local `clk` domain, debounces them, and turns them into clean levels plus one-cycle press, release and (optional) hold events for the local game logic. It sits between the GPIO input pins and the player/game control FSMs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized cycles a new value must persist before it is accepted; legal range ≥ 1.
- `HOLD_CYCLES`, default 32_500_000: cycles a debounced level must stay high before a hold event (0.5 s at 65 MHz); legal range ≥ 1.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `gpio_left_input`  in  1  remote left-button line, asynchronous to `clk`
- `gpio_right_input`  in  1  remote right-button line, asynchronous to `clk`
- `left_level`  out  1  debounced left state
- `right_level`  out  1  debounced right state
- `left_press`  out  1  one-cycle pulse, left 0→1
- `left_release`  out  1  one-cycle pulse, left 1→0
- `right_press`  out  1  one-cycle pulse, right 0→1
- `right_release`  out  1  one-cycle pulse, right 1→0
- `left_hold`  out  1  one-cycle pulse, left long-press
- `right_hold`  out  1  one-cycle pulse, right long-press

## Operation
- There are two identical, independent channels (left, right). Both channels may pulse in the same cycle.
- **Synchronizer:** a 2-FF chain `sync_q1` → `sync_q2`; both stages reset to 0.
- **Debounce:** a counter `db_cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync_q2 == level`: `db_cnt` ← 0.
  - Else if `db_cnt == DEBOUNCE_CYCLES-1`: `level` ← `sync_q2` and `db_cnt` ← 0.
  - Else: `db_cnt` increments.
- A mismatch shorter than `DEBOUNCE_CYCLES` cycles at `sync_q2` is discarded: the counter restarts and the level does not change.
- **Event pulses:**
  - `press` is registered alongside a `level` update to 1, so it is high exactly during the first cycle `level` reads 1.
  - `release` behaves the same way for an update to 0.
  - No pulse is produced without a level change.
- **Hold** (present only with the macro):
  - Saturating counter `hold_cnt`, cleared while `level` is 0 and on the cycle `press` is asserted.
  - Increments each cycle `level` is 1.
  - `hold` pulses for one cycle when `hold_cnt` reaches `HOLD_CYCLES-1`.
  - At most one hold pulse per press; the counter saturates afterwards until release.
- **Reset** (asynchronous): every flop clears, so all outputs read 0 while `rst` is high.
  - After release, a line that is still high is treated as a new press: the full debounce delay applies, then `press` is emitted.
  - A debounce or hold in progress when `rst` is asserted is abandoned. No stale pulse is produced after reset.

## Timing
- **Latency:** count the first rising edge that samples a new stable input value as edge 1.
  - Edge 2: `sync_q2` holds the new value.
  - Edge `DEBOUNCE_CYCLES+2`: `level` and the `press`/`release` pulse update together.
  - Example: with `DEBOUNCE_CYCLES=4`, the level changes after edge 6.
- **Hold timing:** `hold` is asserted exactly `HOLD_CYCLES` cycles after the cycle in which `press` was asserted, provided `level` stays 1 throughout.
- **Pulse width:** every event output is exactly 1 cycle wide. It is never asserted in two consecutive cycles.
- **Reset values:** all outputs are 0; their values are held while `rst` is high.

## Configuration
- Macro `GPIO_LINK_HOLD_EN`.
- **Defined:** the hold counters and logic are built as described above.
- **Undefined:**
  - No hold counters are synthesized and `HOLD_CYCLES` is ignored.
  - `left_hold` and `right_hold` are tied to constant 0.
  - All other behaviour is unchanged.

## Test plan
- **Reset then high input:** `rst`=1 with both inputs at 1 → every output reads 0. After deasserting `rst` with `DEBOUNCE_CYCLES=4`, `left_level` and `right_level` rise after edge 6, with a single `left_press` and `right_press` pulse in that cycle.
- **Glitch rejection:** `gpio_left_input` high for 3 cycles with `DEBOUNCE_CYCLES=4` → `left_level` stays 0 and no `left_press` is emitted. The same input high for 4 cycles → exactly one press.
- **Release:** `left_level`=1, then the input drops to 0 and stays there → exactly one `left_release` after edge 6, then `left_level`=0.
- **Simultaneous:** both inputs rise on the same edge → `left_press` and `right_press` assert in the same cycle. Toggling right only → the left outputs are unaffected.
- **Hold:** `HOLD_CYCLES=10`, input held high for 30 cycles → with `GPIO_LINK_HOLD_EN`, a single `left_hold` arrives exactly 10 cycles after `left_press`. Without the macro, `left_hold` stays 0.
- **Reset mid-operation:** assert `rst` 3 cycles into a debounce, and separately 5 cycles into a hold (`HOLD_CYCLES=10`) → outputs go to 0 immediately, with no press or hold pulse while `rst` is high or in the first cycle after deassertion.

Source files
------------

// File: rtl/gpio_link_rx.sv
// rtl/gpio_link_rx.sv - two-channel GPIO button receiver: sync, debounce, press/release/hold events (hold built with GPIO_LINK_HOLD_EN)

module gpio_link_rx_chan #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 32_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;

  // Two-stage synchronizer for the asynchronous pin
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
  end

  // Debounce: a new value must persist DEBOUNCE_CYCLES cycles; events fire with the level update
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = sync2_q;
      db_cnt_d = '0;
      press_d  = sync2_q;
      rel_d    = ~sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // State registers for synchronizer, debounce and edge events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

`ifdef GPIO_LINK_HOLD_EN
  localparam int HD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_SAT  = HD_W'(HOLD_CYCLES);

  logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Hold counter: restarts on press, saturates one past the hold point so only one pulse occurs
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!level_q || press_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HD_SAT) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Hold counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Press cycle is excluded so HOLD_CYCLES=1 still lands one cycle after press
  assign hold = level_q & ~press_q & (hold_cnt_q == HD_LAST);
`else
  assign hold = 1'b0;
`endif

endmodule

module gpio_link_rx #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 32_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic gpio_left_input,
  input  logic gpio_right_input,
  output logic left_level,
  output logic right_level,
  output logic left_press,
  output logic left_release,
  output logic right_press,
  output logic right_release,
  output logic left_hold,
  output logic right_hold
);

  gpio_link_rx_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_left (
    .clk  (clk),
    .rst  (rst),
    .din  (gpio_left_input),
    .level(left_level),
    .press(left_press),
    .rel  (left_release),
    .hold (left_hold)
  );

  gpio_link_rx_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_right (
    .clk  (clk),
    .rst  (rst),
    .din  (gpio_right_input),
    .level(right_level),
    .press(right_press),
    .rel  (right_release),
    .hold (right_hold)
  );

endmodule

// File: tb/tb_gpio_link_rx.sv
// tb/tb_gpio_link_rx.sv - randomized bench for gpio_link_rx against a sample-history reference model

module tb_gpio_link_rx;

  localparam int D = 4;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gl = 1'b0;
  logic gr = 1'b0;
  logic left_level, right_level, left_press, left_release;
  logic right_press, right_release, left_hold, right_hold;

  always #5 clk = ~clk;

  gpio_link_rx #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .gpio_left_input (gl),
    .gpio_right_input(gr),
    .left_level      (left_level),
    .right_level     (right_level),
    .left_press      (left_press),
    .left_release    (left_release),
    .right_press     (right_press),
    .right_release   (right_release),
    .left_hold       (left_hold),
    .right_hold      (right_hold)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the debounced level flips when the last D values reaching the
  // debouncer (raw samples delayed by two edges) all disagree with the current level.
  bit m_lvl[2], m_press[2], m_rel[2], m_hold[2], m_pv[2];
  int m_press_cyc[2];
  int cyc = 0;
  bit raw_q[2][$];
  bit db_q[2][$];

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 0; m_press[c] = 0; m_rel[c] = 0; m_hold[c] = 0; m_pv[c] = 0;
      raw_q[c].delete();
      db_q[c].delete();
    end
  endtask

  task automatic model_step();
    bit in_v[2];
    bit x, flip;
    in_v[0] = gl;
    in_v[1] = gr;
    cyc++;
    for (int c = 0; c < 2; c++) begin
      x = (raw_q[c].size() >= 2) ? raw_q[c][raw_q[c].size() - 2] : 1'b0;
      raw_q[c].push_back(in_v[c]);
      if (raw_q[c].size() > 4) void'(raw_q[c].pop_front());
      db_q[c].push_back(x);
      if (db_q[c].size() > D) void'(db_q[c].pop_front());
      flip = (db_q[c].size() == D);
      foreach (db_q[c][k]) if (db_q[c][k] == m_lvl[c]) flip = 0;
      m_press[c] = flip && !m_lvl[c];
      m_rel[c]   = flip && m_lvl[c];
      if (flip) m_lvl[c] = ~m_lvl[c];
      if (m_press[c]) begin
        m_press_cyc[c] = cyc;
        m_pv[c] = 1;
      end
`ifdef GPIO_LINK_HOLD_EN
      m_hold[c] = m_pv[c] && m_lvl[c] && (cyc == m_press_cyc[c] + H);
`else
      m_hold[c] = 0;
`endif
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {left_level, right_level, left_press, left_release,
            right_press, right_release, left_hold, right_hold};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_lvl[0], m_lvl[1], m_press[0], m_rel[0],
            m_press[1], m_rel[1], m_hold[0], m_hold[1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    #1;
    check("outs", {24'd0, dut_vec()}, {24'd0, exp_vec()});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_async", {24'd0, dut_vec()}, 32'd0);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  int lp_edge, rp_edge, lp_cnt, rp_cnt, lh_cnt, lh_idx, lp_idx;
  int run_l, run_r;

  initial begin
    model_clear();
    gl = 1'b1;
    gr = 1'b1;
    rst = 1'b1;
    #1;
    check("reset_outs", {24'd0, dut_vec()}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;

    // Both lines high out of reset: press lands on edge D+2 in both channels together
    lp_edge = 0; rp_edge = 0; lp_cnt = 0; rp_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (left_press) begin lp_edge = i; lp_cnt++; end
      if (right_press) begin rp_edge = i; rp_cnt++; end
    end
    check("left_press_edge", lp_edge, D + 2);
    check("right_press_edge", rp_edge, D + 2);
    check("left_press_cnt", lp_cnt, 1);
    check("right_press_cnt", rp_cnt, 1);

    // Release of left only
    gl = 1'b0;
    lp_edge = 0; lp_cnt = 0; rp_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (left_release) begin lp_edge = i; lp_cnt++; end
      if (right_press || right_release) rp_cnt++;
    end
    check("left_release_edge", lp_edge, D + 2);
    check("left_release_cnt", lp_cnt, 1);
    check("right_untouched", rp_cnt, 0);
    gr = 1'b0;
    repeat (10) tick();

    // Glitch of D-1 cycles is rejected, D cycles is accepted
    lp_cnt = 0;
    gl = 1'b1; repeat (D - 1) tick();
    gl = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (left_press) lp_cnt++; end
    check("glitch_press_cnt", lp_cnt, 0);
    gl = 1'b1; repeat (D) begin tick(); if (left_press) lp_cnt++; end
    gl = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (left_press) lp_cnt++; end
    check("min_pulse_press_cnt", lp_cnt, 1);

    // Long press: hold H cycles after press
    gl = 1'b1;
    lh_cnt = 0; lh_idx = -100; lp_idx = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (left_press) lp_idx = i;
      if (left_hold) begin lh_cnt++; lh_idx = i; end
    end
`ifdef GPIO_LINK_HOLD_EN
    check("hold_cnt", lh_cnt, 1);
    check("hold_delay", lh_idx - lp_idx, H);
`else
    check("hold_absent", lh_cnt, 0);
`endif
    gl = 1'b0;
    repeat (10) tick();

    // Reset three cycles into a debounce, line stays high afterwards
    gl = 1'b1;
    repeat (3) tick();
    do_reset(2);
    repeat (12) tick();
    gl = 1'b0;
    repeat (10) tick();

    // Reset five cycles into a hold
    gl = 1'b1;
    lp_idx = 0;
    for (int i = 0; i < 20 && !left_press; i++) tick();
    check("hold_setup_press", {31'd0, left_press}, 32'd1);
    repeat (5) tick();
    do_reset(3);
    repeat (25) tick();
    gl = 1'b0;
    repeat (10) tick();

    // Randomized runs on both channels with occasional asynchronous resets
    run_l = 0;
    run_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_l == 0) begin
        gl = ~gl;
        run_l = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(1, 7);
      end
      if (run_r == 0) begin
        gr = ~gr;
        run_r = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(1, 7);
      end
      run_l--;
      run_r--;
      if ($urandom_range(0, 299) == 0) do_reset(2);
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
